// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch FIFO feeding an instruction register; the IR is split
// into decode fields for the control unit, register file and sign extender.
//
// Ports:
//   clk, reset      clock; asynchronous active-low reset
//   MEM_VALID/DATA  fetched word from the memory read port
//   MEM_READY       queue can accept a word this cycle
//   IR_LOAD         pop the head of the queue into the IR
//   FLUSH           drop every queued word (branch/jump redirect)
//   IR_VALID        IR holds a word that was actually popped
//   UNDERFLOW       one-cycle pulse after an IR_LOAD that found nothing
//   COUNT           number of queued words, 0..DEPTH
//   OPCODE..IMM16   fixed bit fields of the IR
//
// Build option: define IQ_BYPASS_EN to let an IR_LOAD on an empty queue
// take MEM_DATA directly into the IR instead of raising UNDERFLOW.
module instr_prefetch_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MEM_VALID,
   input  logic [31:0]       MEM_DATA,
   output logic              MEM_READY,
   input  logic              IR_LOAD,
   input  logic              FLUSH,
   output logic              IR_VALID,
   output logic              UNDERFLOW,
   output logic [ADDR_W:0]   COUNT,
   output logic [5:0]        OPCODE,
   output logic [4:0]        RS,
   output logic [4:0]        RT,
   output logic [4:0]        RD,
   output logic [4:0]        SHAMT,
   output logic [5:0]        FUNCT,
   output logic [15:0]       IMM16
);

   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   logic [31:0]     mem_q [DEPTH];
   logic [ADDR_W:0] wr_q, wr_d;
   logic [ADDR_W:0] rd_q, rd_d;
   logic [31:0]     ir_q, ir_d;
   logic            vld_q, vld_d;
   logic            uf_q, uf_d;

   logic [ADDR_W:0] cnt;
   logic            full;
   logic            empty;
   logic            byp;
   logic            push;
   logic            pop;
   logic            starve;

   // The extra wrap bit keeps full (difference DEPTH) apart from empty (0).
   assign cnt   = wr_q - rd_q;
   assign full  = (cnt == FULL_CNT);
   assign empty = (cnt == '0);

   // Held low during reset so memory cannot hand over a word that is lost.
   assign MEM_READY = !full && !FLUSH && reset;

`ifdef IQ_BYPASS_EN
   assign byp = IR_LOAD && empty && MEM_VALID && !FLUSH;
`else
   assign byp = 1'b0;
`endif

   // A bypassed word goes straight to the IR and never occupies a slot.
   assign push   = MEM_VALID && MEM_READY && !byp;
   assign pop    = IR_LOAD && !empty && !FLUSH;
   assign starve = IR_LOAD && empty && !FLUSH && !byp;

   always_comb begin
      ir_d  = ir_q;
      vld_d = vld_q;
      uf_d  = starve;
      if (pop) begin
         ir_d  = mem_q[rd_q[ADDR_W-1:0]];
         vld_d = 1'b1;
      end else if (byp) begin
         ir_d  = MEM_DATA;
         vld_d = 1'b1;
      end else if (starve) begin
         vld_d = 1'b0;
      end
      // FLUSH leaves the IR alone so the in-flight instruction completes.
      if (FLUSH) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         wr_d = wr_q + {{ADDR_W{1'b0}}, push};
         rd_d = rd_q + {{ADDR_W{1'b0}}, pop};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         ir_q  <= '0;
         vld_q <= 1'b0;
         uf_q  <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         ir_q  <= ir_d;
         vld_q <= vld_d;
         uf_q  <= uf_d;
      end
   end

   // Storage needs no reset: slots are only read after being written.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[ADDR_W-1:0]] <= MEM_DATA;
   end

   assign COUNT     = cnt;
   assign IR_VALID  = vld_q;
   assign UNDERFLOW = uf_q;
   assign OPCODE    = ir_q[31:26];
   assign RS        = ir_q[25:21];
   assign RT        = ir_q[20:16];
   assign RD        = ir_q[15:11];
   assign SHAMT     = ir_q[10:6];
   assign FUNCT     = ir_q[5:0];
   assign IMM16     = ir_q[15:0];

endmodule
